// File: rtl/dmem_arbiter.sv
// Shares a single-port, synchronous-read data memory between the CPU load/store
// path (fixed priority) and a host/debug port whose wait is bounded by a CPU streak limit.
module dmem_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q,
    output logic              busy,
    output logic              owner
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t              state_r;
    state_t              next_state_s;
    logic                owner_r;
    logic                we_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [DATA_W-1:0]   wdata_r;
    logic [DATA_W-1:0]   cpu_rdata_r;
    logic [DATA_W-1:0]   host_rdata_r;
    logic [3:0]          streak_r;
    logic                any_req_s;
    logic                host_wins_s;

    // The host only beats a pending CPU request once the CPU streak hits the limit.
    assign any_req_s   = cpu_req | host_req;
    assign host_wins_s = host_req & (~cpu_req | (streak_r == LIMIT));

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic: a fixed four-cycle access once a request is accepted.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (any_req_s) begin
                    next_state_s = ISSUE;
                end else begin
                    next_state_s = IDLE;
                end
            end
            ISSUE:   next_state_s = WAIT;
            WAIT:    next_state_s = DONE;
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Output decode from the registered state only, so no request reaches a memory pin.
    always_comb begin
        mem_wren = 1'b0;
        cpu_ack  = 1'b0;
        host_ack = 1'b0;
        busy     = 1'b1;
        case (state_r)
            IDLE:  busy     = 1'b0;
            ISSUE: mem_wren = we_r;
            WAIT:  mem_wren = 1'b0;
            DONE: begin
                cpu_ack  = ~owner_r;
                host_ack = owner_r;
            end
            default: busy = 1'b0;
        endcase
    end

    // Latch the winning request; these registers also drive the memory pins.
    always_ff @(posedge clock) begin
        if (reset) begin
            owner_r <= 1'b0;
            we_r    <= 1'b0;
            addr_r  <= '0;
            wdata_r <= '0;
        end else if ((state_r == IDLE) && any_req_s) begin
            owner_r <= host_wins_s;
            we_r    <= host_wins_s ? host_we    : cpu_we;
            addr_r  <= host_wins_s ? host_addr  : cpu_addr;
            wdata_r <= host_wins_s ? host_wdata : cpu_wdata;
        end
    end

    // CPU streak: counts CPU grants taken while the host waits, saturating at the limit.
    always_ff @(posedge clock) begin
        if (reset) begin
            streak_r <= 4'd0;
        end else if (state_r == IDLE) begin
            if (host_wins_s) begin
                streak_r <= 4'd0;
            end else if (cpu_req && host_req && (streak_r != LIMIT)) begin
                streak_r <= streak_r + 4'd1;
            end else if (!host_req) begin
                streak_r <= 4'd0;
            end
        end
    end

    // Read data lands in the owner's register at the end of WAIT; writes leave it alone.
    always_ff @(posedge clock) begin
        if (reset) begin
            cpu_rdata_r  <= '0;
            host_rdata_r <= '0;
        end else if ((state_r == WAIT) && !we_r) begin
            if (owner_r) begin
                host_rdata_r <= mem_q;
            end else begin
                cpu_rdata_r <= mem_q;
            end
        end
    end

    assign mem_addr   = addr_r;
    assign mem_data   = wdata_r;
    assign owner      = owner_r;
    assign cpu_rdata  = cpu_rdata_r;
    assign host_rdata = host_rdata_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a behavioural synchronous-read memory on the
// memory pins and a shadow copy used to predict every returned word.
module tb_dmem_arbiter;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [15:0] cpu_addr = 16'h0000, cpu_wdata = 16'h0000;
    logic        host_req = 1'b0, host_we = 1'b0;
    logic [15:0] host_addr = 16'h0000, host_wdata = 16'h0000;
    logic        cpu_ack, host_ack, mem_wren, busy, owner;
    logic [15:0] cpu_rdata, host_rdata, mem_addr, mem_data;
    logic [15:0] mem_q = 16'h0000;

    logic [15:0] mem     [0:65535];
    logic [15:0] ref_mem [0:65535];
    logic [15:0] cpu_q[$];
    logic [15:0] host_q[$];
    logic [15:0] cpu_last = 16'h0000;
    logic [15:0] host_last = 16'h0000;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          wren_cnt = 0;

    dmem_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_LIMIT(4)) dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_ack(host_ack), .host_rdata(host_rdata),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q),
        .busy(busy), .owner(owner)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] pat(input logic [15:0] a);
        if (a == 16'h0010) return 16'hBEEF;
        return (a * 16'h9E37) ^ 16'hA5A5;
    endfunction

    // Synchronous-read single-port memory.
    always @(posedge clock) begin
        if (mem_wren) mem[mem_addr] <= mem_data;
        mem_q <= mem[mem_addr];
    end

    // Cycle counter and write-enable pulse counter.
    always @(posedge clock) cyc <= cyc + 1;
    always @(negedge clock) if (mem_wren) wren_cnt <= wren_cnt + 1;

    task automatic access(input bit host, input bit we, input logic [15:0] addr,
                          input logic [15:0] wdata, input string nm);
        logic [15:0] exp_v, got;
        bit seen, other;
        @(posedge clock); #1;
        if (we) begin
            exp_v = host ? host_last : cpu_last;
            ref_mem[addr] = wdata;
        end else begin
            exp_v = ref_mem[addr];
            if (host) host_last = exp_v; else cpu_last = exp_v;
        end
        if (host) begin
            host_q.push_back(exp_v);
            host_req = 1'b1; host_we = we; host_addr = addr; host_wdata = wdata;
        end else begin
            cpu_q.push_back(exp_v);
            cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        end
        seen = 1'b0;
        other = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clock);
            seen  = host ? host_ack : cpu_ack;
            other = host ? cpu_ack : host_ack;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s_ack: ack=0 after 20 cycles, required 1", nm);
            if (host) void'(host_q.pop_front()); else void'(cpu_q.pop_front());
        end else begin
            got   = host ? host_rdata : cpu_rdata;
            exp_v = host ? host_q.pop_front() : cpu_q.pop_front();
            checks++;
            if (got !== exp_v) begin
                failures++;
                $display("FAIL %s_rdata: got %h required %h", nm, got, exp_v);
            end
            checks++;
            if (other !== 1'b0) begin
                failures++;
                $display("FAIL %s_other_ack: got %b required 0", nm, other);
            end
        end
        if (host) host_req = 1'b0; else cpu_req = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checks++;
        if ({cpu_ack, host_ack, mem_wren, busy, owner} !== 5'b00000) begin
            failures++;
            $display("FAIL reset_ctrl: ack/ack/wren/busy/owner=%b required 00000",
                     {cpu_ack, host_ack, mem_wren, busy, owner});
        end
        checks++;
        if ({cpu_rdata, host_rdata} !== 32'h0) begin
            failures++;
            $display("FAIL reset_rdata: got %h/%h required 0000/0000", cpu_rdata, host_rdata);
        end
        checks++;
        if ({mem_addr, mem_data} !== 32'h0) begin
            failures++;
            $display("FAIL reset_mem: addr %h data %h required 0000/0000", mem_addr, mem_data);
        end
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    task automatic test_cpu_latency();
        @(posedge clock); #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
        cpu_q.push_back(ref_mem[16'h0010]);
        cpu_last = ref_mem[16'h0010];
        @(negedge clock);
        checks++;
        if ({busy, cpu_ack} !== 2'b00) begin
            failures++;
            $display("FAIL lat_c0: busy/ack=%b required 00", {busy, cpu_ack});
        end
        @(negedge clock);
        checks++;
        if ({mem_addr, mem_wren, busy, owner, cpu_ack} !== {16'h0010, 4'b0100}) begin
            failures++;
            $display("FAIL lat_c1: addr %h wren/busy/owner/ack %b required 0010 0100",
                     mem_addr, {mem_wren, busy, owner, cpu_ack});
        end
        @(negedge clock);
        checks++;
        if ({cpu_ack, host_ack} !== 2'b00) begin
            failures++;
            $display("FAIL lat_c2_ack: got %b required 00", {cpu_ack, host_ack});
        end
        @(negedge clock);
        checks++;
        if ({cpu_ack, host_ack} !== 2'b10) begin
            failures++;
            $display("FAIL lat_c3_ack: got %b required 10", {cpu_ack, host_ack});
        end else begin
            checks++;
            if (cpu_rdata !== cpu_q[0]) begin
                failures++;
                $display("FAIL lat_c3_rdata: got %h required %h", cpu_rdata, cpu_q[0]);
            end
        end
        void'(cpu_q.pop_front());
        cpu_req = 1'b0;
        @(negedge clock);
        checks++;
        if ({cpu_ack, busy} !== 2'b00) begin
            failures++;
            $display("FAIL lat_c4: ack/busy=%b required 00", {cpu_ack, busy});
        end
    endtask

    task automatic test_host_write_read();
        int w0;
        w0 = wren_cnt;
        access(1'b1, 1'b1, 16'h0042, 16'h1234, "host_wr");
        @(posedge clock); #1;
        checks++;
        if (wren_cnt - w0 !== 1) begin
            failures++;
            $display("FAIL wren_pulses: got %0d required 1", wren_cnt - w0);
        end
        checks++;
        if (mem[16'h0042] !== 16'h1234) begin
            failures++;
            $display("FAIL mem_written: got %h required 1234", mem[16'h0042]);
        end
        access(1'b1, 1'b0, 16'h0042, 16'h0000, "host_rd");
        checks++;
        if (cpu_rdata !== 16'hBEEF) begin
            failures++;
            $display("FAIL cpu_rdata_kept: got %h required beef", cpu_rdata);
        end
    endtask

    task automatic test_contention();
        logic [9:0] exp_order;
        bit         order[10];
        int         when[10];
        int         n;
        exp_order = 10'b10_0001_0000;
        n = 0;
        @(posedge clock); #1;
        for (int i = 0; i < 8; i++) cpu_q.push_back(ref_mem[16'h0100]);
        for (int i = 0; i < 2; i++) host_q.push_back(ref_mem[16'h0200]);
        cpu_last = ref_mem[16'h0100];
        host_last = ref_mem[16'h0200];
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0100;
        host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0200;
        for (int c = 0; c < 60 && n < 10; c++) begin
            @(negedge clock);
            if (cpu_ack && n < 10) begin
                order[n] = 1'b0; when[n] = cyc; n++;
                checks++;
                if (cpu_q.size() == 0 || cpu_rdata !== cpu_q[0]) begin
                    failures++;
                    $display("FAIL cont_cpu_rdata: got %h unexpected or wrong", cpu_rdata);
                end
                if (cpu_q.size() != 0) void'(cpu_q.pop_front());
            end
            if (host_ack && n < 10) begin
                order[n] = 1'b1; when[n] = cyc; n++;
                checks++;
                if (host_q.size() == 0 || host_rdata !== host_q[0]) begin
                    failures++;
                    $display("FAIL cont_host_rdata: got %h unexpected or wrong", host_rdata);
                end
                if (host_q.size() != 0) void'(host_q.pop_front());
            end
        end
        cpu_req = 1'b0;
        host_req = 1'b0;
        checks++;
        if (n != 10) begin
            failures++;
            $display("FAIL cont_count: got %0d acks required 10", n);
        end
        for (int i = 0; i < n; i++) begin
            checks++;
            if (order[i] !== exp_order[i]) begin
                failures++;
                $display("FAIL cont_order[%0d]: got %s required %s", i,
                         order[i] ? "H" : "C", exp_order[i] ? "H" : "C");
            end
            if (i > 0) begin
                checks++;
                if (when[i] - when[i-1] != 4) begin
                    failures++;
                    $display("FAIL cont_spacing[%0d]: got %0d required 4", i, when[i] - when[i-1]);
                end
            end
        end
        cpu_q.delete();
        host_q.delete();
    endtask

    task automatic test_simultaneous();
        int  t_cpu;
        bit  seen;
        @(posedge clock); #1;
        cpu_q.push_back(ref_mem[16'h0005]);
        host_q.push_back(ref_mem[16'h0006]);
        cpu_last = ref_mem[16'h0005];
        host_last = ref_mem[16'h0006];
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0005;
        host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0006;
        seen = 1'b0; t_cpu = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clock);
            seen = cpu_ack | host_ack;
        end
        checks++;
        if ({cpu_ack, host_ack, owner} !== 3'b100) begin
            failures++;
            $display("FAIL sim_first: cpu_ack/host_ack/owner=%b required 100",
                     {cpu_ack, host_ack, owner});
        end
        checks++;
        if (cpu_rdata !== cpu_q[0]) begin
            failures++;
            $display("FAIL sim_cpu_rdata: got %h required %h", cpu_rdata, cpu_q[0]);
        end
        void'(cpu_q.pop_front());
        t_cpu = cyc;
        cpu_req = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clock);
            seen = host_ack;
        end
        checks++;
        if (!seen || owner !== 1'b1 || cyc - t_cpu != 4) begin
            failures++;
            $display("FAIL sim_host_ack: seen %b owner %b after %0d cycles required 1 1 4",
                     seen, owner, cyc - t_cpu);
        end
        checks++;
        if (host_rdata !== host_q[0]) begin
            failures++;
            $display("FAIL sim_host_rdata: got %h required %h", host_rdata, host_q[0]);
        end
        void'(host_q.pop_front());
        host_req = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(posedge clock); #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0020;
        @(negedge clock);
        @(negedge clock);
        @(negedge clock);
        checks++;
        if ({busy, mem_wren, cpu_ack} !== 3'b100) begin
            failures++;
            $display("FAIL rst_mid_wait: busy/wren/ack=%b required 100", {busy, mem_wren, cpu_ack});
        end
        reset = 1'b1;
        cpu_req = 1'b0;
        @(negedge clock);
        checks++;
        if ({cpu_ack, busy, mem_wren} !== 3'b000) begin
            failures++;
            $display("FAIL rst_mid_ctrl: ack/busy/wren=%b required 000", {cpu_ack, busy, mem_wren});
        end
        checks++;
        if (cpu_rdata !== 16'h0000) begin
            failures++;
            $display("FAIL rst_mid_rdata: got %h required 0000", cpu_rdata);
        end
        reset = 1'b0;
        cpu_last = 16'h0000;
        host_last = 16'h0000;
        @(negedge clock);
        checks++;
        if (cpu_ack !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_late_ack: got %b required 0", cpu_ack);
        end
        access(1'b0, 1'b0, 16'h0021, 16'h0000, "post_reset_rd");
    endtask

    task automatic test_addr_change();
        @(posedge clock); #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0003;
        cpu_q.push_back(ref_mem[16'h0003]);
        cpu_last = ref_mem[16'h0003];
        @(negedge clock);
        @(posedge clock); #1;
        cpu_addr = 16'h0007;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            checks++;
            if (mem_addr !== 16'h0003) begin
                failures++;
                $display("FAIL addr_hold[%0d]: got %h required 0003", i, mem_addr);
            end
        end
        @(negedge clock);
        checks++;
        if (cpu_ack !== 1'b1) begin
            failures++;
            $display("FAIL addr_chg_ack: got %b required 1", cpu_ack);
        end
        checks++;
        if (cpu_rdata !== cpu_q[0]) begin
            failures++;
            $display("FAIL addr_chg_rdata: got %h required %h", cpu_rdata, cpu_q[0]);
        end
        void'(cpu_q.pop_front());
        cpu_req = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i] = pat(16'(i));
            ref_mem[i] = pat(16'(i));
        end
        test_reset();
        test_cpu_latency();
        test_host_write_read();
        test_contention();
        test_simultaneous();
        test_reset_mid();
        test_addr_change();
        repeat (2) @(posedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
